// File: rtl/tile_pwr_seq_ctrl.sv
// Per-tile clock-enable / reset power sequencer with request/acknowledge handshake.
// Each tile runs an independent FSM; all outputs are registered from the next state.
module tile_pwr_seq_ctrl #(
    parameter int unsigned           NumTiles   = 16,
    parameter int unsigned           RstCycles  = 8,
    parameter int unsigned           IdleCycles = 4,
    parameter logic [NumTiles-1:0]   DefaultOn  = '0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NumTiles-1:0] on_req_i,
    input  logic [NumTiles-1:0] idle_i,
    output logic [NumTiles-1:0] tile_clk_en_o,
    output logic [NumTiles-1:0] tile_rst_no,
    output logic [NumTiles-1:0] on_o,
    output logic [NumTiles-1:0] ack_o,
    output logic                busy_o
);

    localparam int unsigned MaxCnt   = (RstCycles > IdleCycles) ? RstCycles : IdleCycles;
    localparam int unsigned CntWidth = $clog2(MaxCnt + 1);
    localparam logic [CntWidth-1:0] RstLoad  = CntWidth'(RstCycles - 1);
    localparam logic [CntWidth-1:0] IdleLoad = CntWidth'(IdleCycles - 1);
    localparam logic [CntWidth-1:0] CntOne   = CntWidth'(1);

    typedef enum logic [2:0] {
        OFF,
        PWRUP,
        ON,
        DRAIN,
        PWRDN
    } state_e;

    state_e              state_q [NumTiles];
    state_e              state_d [NumTiles];
    logic [CntWidth-1:0] cnt_q   [NumTiles];
    logic [CntWidth-1:0] cnt_d   [NumTiles];
    logic [NumTiles-1:0] ack_d;
    logic                busy_d;

    always_comb begin
        busy_d = 1'b0;
        ack_d  = '0;
        for (int unsigned t = 0; t < NumTiles; t++) begin
            state_d[t] = state_q[t];
            cnt_d[t]   = cnt_q[t];
            case (state_q[t])
                OFF: begin
                    if (on_req_i[t]) begin
                        state_d[t] = PWRUP;
                        cnt_d[t]   = RstLoad;
                    end
                end
                PWRUP: begin
                    if (cnt_q[t] != '0) begin
                        cnt_d[t] = cnt_q[t] - CntOne;
                    end else begin
                        state_d[t] = ON;
                        ack_d[t]   = 1'b1;
                    end
                end
                ON: begin
                    if (!on_req_i[t]) begin
                        state_d[t] = DRAIN;
                        cnt_d[t]   = IdleLoad;
                    end
                end
                DRAIN: begin
                    // Any non-idle cycle restarts the consecutive-idle window.
                    if (on_req_i[t]) begin
                        state_d[t] = ON;
                    end else if (!idle_i[t]) begin
                        cnt_d[t] = IdleLoad;
                    end else if (cnt_q[t] != '0) begin
                        cnt_d[t] = cnt_q[t] - CntOne;
                    end else begin
                        state_d[t] = PWRDN;
                        cnt_d[t]   = RstLoad;
                    end
                end
                PWRDN: begin
                    if (cnt_q[t] != '0) begin
                        cnt_d[t] = cnt_q[t] - CntOne;
                    end else begin
                        state_d[t] = OFF;
                        ack_d[t]   = 1'b1;
                    end
                end
                default: begin
                    state_d[t] = OFF;
                    cnt_d[t]   = '0;
                end
            endcase
            if (state_d[t] != OFF && state_d[t] != ON) begin
                busy_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned t = 0; t < NumTiles; t++) begin
                state_q[t] <= DefaultOn[t] ? PWRUP : OFF;
                cnt_q[t]   <= DefaultOn[t] ? RstLoad : '0;
            end
            tile_clk_en_o <= DefaultOn;
            tile_rst_no   <= '0;
            on_o          <= '0;
            ack_o         <= '0;
            busy_o        <= |DefaultOn;
        end else begin
            for (int unsigned t = 0; t < NumTiles; t++) begin
                state_q[t]       <= state_d[t];
                cnt_q[t]         <= cnt_d[t];
                tile_clk_en_o[t] <= (state_d[t] != OFF);
                tile_rst_no[t]   <= (state_d[t] == ON) || (state_d[t] == DRAIN);
                on_o[t]          <= (state_d[t] == ON);
            end
            ack_o  <= ack_d;
            busy_o <= busy_d;
        end
    end

    a_rst_needs_clk: assert property (@(posedge clk_i) disable iff (rst_i)
        (tile_rst_no & ~tile_clk_en_o) == '0);
    a_ack_single: assert property (@(posedge clk_i) disable iff (rst_i)
        (ack_o & $past(ack_o)) == '0);

endmodule

// File: tb/tb_tile_pwr_seq_ctrl.sv
// Directed bench for tile_pwr_seq_ctrl: one instance with DefaultOn=0, one with DefaultOn=16'h0003.
module tb_tile_pwr_seq_ctrl;

    logic        clk;
    logic        rst, rst_b;
    logic [15:0] on_req, idle, on_req_b, idle_b;
    logic [15:0] clk_en, rst_n, on, ack;
    logic [15:0] clk_en_b, rst_n_b, on_b, ack_b;
    logic        busy, busy_b;
    int          total = 0;
    int          bad   = 0;
    logic [6:0]  pat;

    tile_pwr_seq_ctrl #(
        .NumTiles(16), .RstCycles(8), .IdleCycles(4), .DefaultOn(16'h0000)
    ) dut (
        .clk_i(clk), .rst_i(rst), .on_req_i(on_req), .idle_i(idle),
        .tile_clk_en_o(clk_en), .tile_rst_no(rst_n), .on_o(on),
        .ack_o(ack), .busy_o(busy)
    );

    tile_pwr_seq_ctrl #(
        .NumTiles(16), .RstCycles(8), .IdleCycles(4), .DefaultOn(16'h0003)
    ) dut_b (
        .clk_i(clk), .rst_i(rst_b), .on_req_i(on_req_b), .idle_i(idle_b),
        .tile_clk_en_o(clk_en_b), .tile_rst_no(rst_n_b), .on_o(on_b),
        .ack_o(ack_b), .busy_o(busy_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; rst_b = 1'b1;
        on_req = '0; idle = '1; on_req_b = 16'h0003; idle_b = '1;
        step(); step();
        chk("rst_clk_en", clk_en, 16'h0000);
        chk("rst_rst_n", rst_n, 16'h0000);
        chk("rst_on", on, 16'h0000);
        chk("rst_ack", ack, 16'h0000);
        chk("rst_busy", {15'd0, busy}, 16'h0000);
        chk("rstb_clk_en", clk_en_b, 16'h0003);
        chk("rstb_rst_n", rst_n_b, 16'h0000);
        chk("rstb_busy", {15'd0, busy_b}, 16'h0001);
        rst = 1'b0;
        step();

        // power-up tile 0
        on_req[0] = 1'b1;
        step();
        chk("up_e0_clk_en", clk_en, 16'h0001);
        chk("up_e0_rst_n", rst_n, 16'h0000);
        chk("up_e0_busy", {15'd0, busy}, 16'h0001);
        repeat (7) step();
        chk("up_e7_rst_n", rst_n, 16'h0000);
        chk("up_e7_ack", ack, 16'h0000);
        chk("up_e7_busy", {15'd0, busy}, 16'h0001);
        step();
        chk("up_e8_rst_n", rst_n, 16'h0001);
        chk("up_e8_on", on, 16'h0001);
        chk("up_e8_ack", ack, 16'h0001);
        chk("up_e8_busy", {15'd0, busy}, 16'h0000);
        step();
        chk("up_e9_ack", ack, 16'h0000);
        chk("up_e9_on", on, 16'h0001);

        // power-down tile 0, idle constant
        on_req[0] = 1'b0;
        step();
        chk("dn_e0_on", on, 16'h0000);
        chk("dn_e0_rst_n", rst_n, 16'h0001);
        chk("dn_e0_busy", {15'd0, busy}, 16'h0001);
        repeat (3) step();
        chk("dn_e3_rst_n", rst_n, 16'h0001);
        step();
        chk("dn_e4_rst_n", rst_n, 16'h0000);
        chk("dn_e4_clk_en", clk_en, 16'h0001);
        repeat (7) step();
        chk("dn_e11_clk_en", clk_en, 16'h0001);
        chk("dn_e11_ack", ack, 16'h0000);
        step();
        chk("dn_e12_clk_en", clk_en, 16'h0000);
        chk("dn_e12_ack", ack, 16'h0001);
        chk("dn_e12_busy", {15'd0, busy}, 16'h0000);
        step();
        chk("dn_e13_ack", ack, 16'h0000);

        // back on, then idle reload during DRAIN (pattern 1,1,0,1,1,1,1)
        on_req[0] = 1'b1;
        repeat (9) step();
        chk("re_on", on, 16'h0001);
        on_req[0] = 1'b0;
        step();
        pat = 7'b1111011;
        for (int i = 0; i < 6; i++) begin
            idle[0] = pat[i];
            step();
            chk("reload_rst_n_hi", rst_n, 16'h0001);
        end
        idle[0] = pat[6];
        step();
        chk("reload_e7_rst_n", rst_n, 16'h0000);
        chk("reload_e7_clk_en", clk_en, 16'h0001);

        // re-request mid-PWRDN: OFF still reached with ack, then PWRUP next edge
        idle[0] = 1'b1;
        step(); step();
        on_req[0] = 1'b1;
        repeat (5) step();
        chk("pdreq_e14_clk_en", clk_en, 16'h0001);
        chk("pdreq_e14_rst_n", rst_n, 16'h0000);
        step();
        chk("pdreq_e15_clk_en", clk_en, 16'h0000);
        chk("pdreq_e15_ack", ack, 16'h0001);
        chk("pdreq_e15_on", on, 16'h0000);
        step();
        chk("pdreq_e16_clk_en", clk_en, 16'h0001);
        chk("pdreq_e16_ack", ack, 16'h0000);
        chk("pdreq_e16_busy", {15'd0, busy}, 16'h0001);
        repeat (8) step();
        chk("pdreq_e24_on", on, 16'h0001);
        chk("pdreq_e24_ack", ack, 16'h0001);

        // abort in DRAIN
        on_req[0] = 1'b0;
        step();
        step();
        chk("abort_e1_on", on, 16'h0000);
        chk("abort_e1_rst_n", rst_n, 16'h0001);
        on_req[0] = 1'b1;
        step();
        chk("abort_e2_on", on, 16'h0001);
        chk("abort_e2_rst_n", rst_n, 16'h0001);
        chk("abort_e2_ack", ack, 16'h0000);
        chk("abort_e2_busy", {15'd0, busy}, 16'h0000);

        // several tiles in parallel
        on_req = on_req | 16'h8420;
        step();
        chk("par_e0_clk_en", clk_en, 16'h8421);
        chk("par_e0_rst_n", rst_n, 16'h0001);
        repeat (7) step();
        chk("par_e7_ack", ack, 16'h0000);
        step();
        chk("par_e8_rst_n", rst_n, 16'h8421);
        chk("par_e8_ack", ack, 16'h8420);
        chk("par_e8_on", on, 16'h8421);

        // DefaultOn instance: auto power-up, then async reset mid-ON
        rst_b = 1'b0;
        repeat (7) step();
        chk("def_e7_rst_n", rst_n_b, 16'h0000);
        chk("def_e7_ack", ack_b, 16'h0000);
        step();
        chk("def_e8_rst_n", rst_n_b, 16'h0003);
        chk("def_e8_ack", ack_b, 16'h0003);
        chk("def_e8_clk_en", clk_en_b, 16'h0003);
        on_req_b = 16'h0023;
        repeat (9) step();
        chk("def_t5_on", on_b, 16'h0023);
        #2;
        rst_b = 1'b1;
        #1;
        chk("async_rst_n", rst_n_b, 16'h0000);
        chk("async_clk_en", clk_en_b, 16'h0003);
        chk("async_on", on_b, 16'h0000);
        chk("async_busy", {15'd0, busy_b}, 16'h0001);
        on_req_b = 16'h0003;
        step();
        rst_b = 1'b0;
        repeat (7) step();
        chk("rel_e7_ack", ack_b, 16'h0000);
        chk("rel_e7_rst_n", rst_n_b, 16'h0000);
        step();
        chk("rel_e8_rst_n", rst_n_b, 16'h0003);
        chk("rel_e8_ack", ack_b, 16'h0003);
        chk("rel_e8_on", on_b, 16'h0003);
        chk("rel_e8_clk_en", clk_en_b, 16'h0003);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
